// File: rtl/dummy_dac_pkg.sv
// Shared definitions for the dummy DAC/ADC slot test blocks.
// Holds the FSM state encoding, FIFO geometry, the default test pattern
// and a saturating counter helper.
package dummy_dac_pkg;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned LANES    = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned IDX_W    = 2;

    localparam logic [WORD_W-1:0] DEFAULT_EXPECTED = 32'hDEADBEEF;
    localparam logic [CNT_W-1:0]  SAT_MAX          = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    // Increment that sticks at SAT_MAX.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: free-running counter 0..CLK_DIV-1,
// tick is high for the single cycle in which the counter holds CLK_DIV-1.
// Ports: clk, reset (sync, active-high), tick (decoded from the counter register).
module sample_tick_gen #(
    parameter int unsigned CLK_DIV = 256
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count;

    // Period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/dummy_dac.sv
// Test-only DAC-side slot sink. On each sample tick (DAC direction) it reads
// four bytes from the slot FIFO, assembles them little-endian into a word,
// presents the word and compares it against EXPECTED.
// Ports: clk, reset (sync, active-high); fifo_data/fifo_read FIFO read side;
// fifo_addr_in/fifo_addr_out FIFO pointers (fill level); direction (0 = active);
// sample_data/sample_valid/match last word; underrun_count, error_count saturating.
module dummy_dac
    import dummy_dac_pkg::*;
#(
    parameter int unsigned       CLK_DIV  = 256,
    parameter logic [WORD_W-1:0] EXPECTED = DEFAULT_EXPECTED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] fifo_data,
    output logic              fifo_read,
    input  logic [ADDR_W-1:0] fifo_addr_in,
    input  logic [ADDR_W-1:0] fifo_addr_out,
    input  logic              direction,
    output logic [WORD_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              match,
    output logic [CNT_W-1:0]  underrun_count,
    output logic [CNT_W-1:0]  error_count
);

    logic              tick;
    logic [ADDR_W-1:0] level;
    logic [WORD_W-1:0] word_c;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cap_en_q;
    logic [IDX_W-1:0]  cap_idx_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    logic              fifo_read_d, sample_valid_d, match_d;
    logic [WORD_W-1:0] sample_data_d;
    logic [CNT_W-1:0]  underrun_d, error_d;

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Modulo-2048 fill level
    assign level = fifo_addr_in - fifo_addr_out;

    // Byte 3 arrives during DRAIN, so the finished word combines it with lanes 0..2
    assign word_c = {fifo_data, shreg_q[WORD_W-BYTE_W-1:0]};

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cap_en_q       <= 1'b0;
            cap_idx_q      <= '0;
            shreg_q        <= '0;
            fifo_read      <= 1'b0;
            sample_data    <= '0;
            sample_valid   <= 1'b0;
            match          <= 1'b0;
            underrun_count <= '0;
            error_count    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cap_en_q       <= fifo_read;
            cap_idx_q      <= idx_q;
            shreg_q        <= shreg_d;
            fifo_read      <= fifo_read_d;
            sample_data    <= sample_data_d;
            sample_valid   <= sample_valid_d;
            match          <= match_d;
            underrun_count <= underrun_d;
            error_count    <= error_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shreg_d        = shreg_q;
        fifo_read_d    = 1'b0;
        sample_data_d  = sample_data;
        sample_valid_d = 1'b0;
        match_d        = match;
        underrun_d     = underrun_count;
        error_d        = error_count;

        // Byte read in READ cycle k lands one cycle later, tagged by the delayed index
        if (cap_en_q) begin
            shreg_d[BYTE_W*cap_idx_q +: BYTE_W] = fifo_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick && !direction) begin
                    if (level >= ADDR_W'(LANES)) begin
                        state_d     = ST_READ;
                        idx_d       = '0;
                        fifo_read_d = 1'b1;
                    end else begin
                        underrun_d = sat_inc(underrun_count);
                    end
                end
            end
            ST_READ: begin
                if (idx_q == IDX_W'(LANES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                    fifo_read_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                sample_data_d  = word_c;
                sample_valid_d = 1'b1;
                match_d        = (word_c == EXPECTED);
                state_d        = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (!match) begin
                    error_d = sat_inc(error_count);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dummy_dac.sv
// Self-checking bench for dummy_dac: directed scenarios plus randomized
// ticks, checked against a transaction-level model of the sink.
module tb_dummy_dac;

    localparam int unsigned CLK_DIV = 8;
    localparam logic [31:0] EXP_W   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  fifo_data;
    logic        fifo_read;
    logic [10:0] fifo_addr_in;
    logic [10:0] fifo_addr_out;
    logic        direction;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        match;
    logic [15:0] underrun_count;
    logic [15:0] error_count;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    // Model state
    logic [7:0]  byte_q[$];
    logic [31:0] m_data;
    logic        m_match;
    logic [15:0] m_und;
    logic [15:0] m_err;

    dummy_dac #(.CLK_DIV(CLK_DIV), .EXPECTED(EXP_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_data      (fifo_data),
        .fifo_read      (fifo_read),
        .fifo_addr_in   (fifo_addr_in),
        .fifo_addr_out  (fifo_addr_out),
        .direction      (direction),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .match          (match),
        .underrun_count (underrun_count),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    // Slot FIFO model: data valid the cycle after a sampled read
    always @(posedge clk) begin
        if (fifo_read) begin
            if (byte_q.size() > 0) fifo_data <= byte_q.pop_front();
            else                   fifo_data <= 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt = (cnt + 1) % CLK_DIV;
    endtask

    task automatic model_clear();
        byte_q.delete();
        m_data  = '0;
        m_match = 1'b0;
        m_und   = '0;
        m_err   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cnt = 0;
        model_clear();
    endtask

    function automatic logic [15:0] sat1(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One sample period: set inputs, run to the tick, check the outcome.
    task automatic do_tick(input logic d, input logic [10:0] ain, input logic [10:0] aout,
                           input logic [31:0] w, input bit flip);
        int lvl;
        bit go;
        lvl = int'((ain - aout) & 11'h7FF);
        go  = !d && (lvl >= 4);
        if (go) for (int k = 0; k < 4; k++) byte_q.push_back(w[8*k +: 8]);
        direction     = d;
        fifo_addr_in  = ain;
        fifo_addr_out = aout;
        while (cnt != CLK_DIV - 1) begin
            step();
            chk("rd_before_tick", 32'(fifo_read), 32'd0);
        end
        if (go) begin
            for (int k = 1; k <= 4; k++) begin
                step();
                if (flip && k == 2) direction = ~d;
                chk("rd_pulse", 32'(fifo_read), 32'd1);
                chk("valid_early", 32'(sample_valid), 32'd0);
            end
            step();
            chk("rd_after4", 32'(fifo_read), 32'd0);
            m_data  = w;
            m_match = (w == EXP_W);
            step();
            chk("valid_pulse", 32'(sample_valid), 32'd1);
            chk("sample_data", sample_data, m_data);
            chk("match", 32'(match), 32'(m_match));
            if (!m_match) m_err = sat1(m_err);
            step();
            chk("valid_clear", 32'(sample_valid), 32'd0);
            chk("error_count", 32'(error_count), 32'(m_err));
            chk("underrun_hold", 32'(underrun_count), 32'(m_und));
            direction = d;
        end else begin
            if (!d) m_und = sat1(m_und);
            step();
            chk("no_read", 32'(fifo_read), 32'd0);
            chk("underrun_count", 32'(underrun_count), 32'(m_und));
            chk("error_hold", 32'(error_count), 32'(m_err));
            chk("data_hold", sample_data, m_data);
        end
    endtask

    initial begin
        logic [10:0] ao;
        logic [31:0] w;
        fifo_data     = 8'h00;
        direction     = 1'b0;
        fifo_addr_in  = '0;
        fifo_addr_out = '0;
        model_clear();

        // Reset values
        do_reset();
        chk("rst_fifo_read", 32'(fifo_read), 32'd0);
        chk("rst_sample_data", sample_data, 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_underrun", 32'(underrun_count), 32'd0);
        chk("rst_error", 32'(error_count), 32'd0);

        // Matching word, then a mismatching word
        do_tick(1'b0, 11'd4, 11'd0, 32'hDEADBEEF, 1'b0);
        do_tick(1'b0, 11'd4, 11'd0, 32'h04030201, 1'b0);

        // Three underruns at level 3
        for (int i = 0; i < 3; i++) do_tick(1'b0, 11'd3, 11'd0, 32'h0, 1'b0);
        chk("underrun_three", 32'(underrun_count), 32'd3);

        // Pointer wrap gives level 4
        do_tick(1'b0, 11'd2, 11'd2046, 32'hDEADBEEF, 1'b0);

        // Direction flips mid-word; the word still completes
        do_tick(1'b0, 11'd10, 11'd0, 32'hCAFEF00D, 1'b1);

        // Reset in T+3 of a transaction
        w = 32'h11223344;
        for (int k = 0; k < 4; k++) byte_q.push_back(w[8*k +: 8]);
        direction = 1'b0; fifo_addr_in = 11'd4; fifo_addr_out = 11'd0;
        while (cnt != CLK_DIV - 1) step();
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("rst_mid_rd", 32'(fifo_read), 32'd1);
        end
        reset = 1'b1;
        step();
        chk("mid_rst_rd", 32'(fifo_read), 32'd0);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_data", sample_data, 32'd0);
        chk("mid_rst_match", 32'(match), 32'd0);
        chk("mid_rst_underrun", 32'(underrun_count), 32'd0);
        chk("mid_rst_error", 32'(error_count), 32'd0);
        reset = 1'b0;
        cnt = 0;
        model_clear();
        do_tick(1'b0, 11'd4, 11'd0, 32'hDEADBEEF, 1'b0);

        // ADC direction: idle for 10 ticks with plenty of data
        for (int i = 0; i < 10; i++) do_tick(1'b1, 11'd64, 11'd0, 32'h0, 1'b0);
        chk("adc_underrun", 32'(underrun_count), 32'(m_und));

        // Saturation of the underrun counter
        force dut.underrun_count = 16'hFFFF;
        step();
        release dut.underrun_count;
        m_und = 16'hFFFF;
        do_tick(1'b0, 11'd1, 11'd0, 32'h0, 1'b0);
        chk("underrun_sat", 32'(underrun_count), 32'hFFFF);

        // Randomized ticks
        for (int i = 0; i < 40; i++) begin
            ao = 11'($urandom_range(0, 2047));
            w  = ($urandom_range(0, 1) == 0) ? EXP_W : $urandom;
            do_tick(($urandom_range(0, 4) == 0), ao + 11'($urandom_range(0, 7)), ao, w,
                    ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dummy_dac.md
# dummy_dac

Test-only sink on the DAC side of a slot: drains bytes from the slot FIFO at a fixed sample rate and reassembles them little-endian into 32-bit words. Each word is checked against a fixed expected pattern, with mismatch and underrun counters. It sits directly downstream of the slot FIFO. It exercises the host→FIFO→converter path in cosimulation the same way the dummy ADC exercises converter→FIFO→host.

## Interface
Parameters:
- CLK_DIV, 256, clk cycles per sample period (100 MHz / 256 ≈ 390.6 kHz); legal range 8..65535.
- EXPECTED, 32'hDEADBEEF, word every received sample is compared against.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  reset, synchronous, active-high; clock clk.
- fifo_data  input  8  FIFO read data, valid the cycle after fifo_read is sampled high.
- fifo_read  output  1  FIFO read strobe, one byte per cycle high.
- fifo_addr_in  input  11  FIFO write pointer.
- fifo_addr_out  input  11  FIFO read pointer.
- direction  input  1  0 = DAC slot (block active), 1 = ADC slot (block idle).
- sample_data  output  32  last assembled word.
- sample_valid  output  1  one-cycle pulse when sample_data updates.
- match  output  1  last word == EXPECTED.
- underrun_count  output  16  sample ticks with fewer than 4 bytes available, saturating.
- error_count  output  16  assembled words != EXPECTED, saturating.

## Operation
- Tick generator: counter 0..CLK_DIV-1, wraps to 0. tick = (counter == CLK_DIV-1). Runs regardless of direction.
- level = (fifo_addr_in - fifo_addr_out) mod 2048, 11-bit unsigned wrap subtraction.
- FSM states: IDLE, READ (4 cycles, byte index 0..3), DRAIN (1 cycle, last byte lands), PRESENT (1 cycle).
- IDLE, tick, direction==0, level>=4 → READ, idx=0.
- IDLE, tick, direction==0, level<4 → underrun_count+1 (saturates at 16'hFFFF); stay IDLE; no read.
- IDLE, direction==1 → no reads, no counter changes.
- READ: fifo_read=1; idx increments each cycle; idx==3 → DRAIN.
- Byte k (read in READ cycle k) is captured into bits [8k+7:8k] of the shift register one cycle later.
- PRESENT: sample_data ← assembled word; sample_valid=1; match ← (word==EXPECTED); error_count+1 (saturating) if mismatch; → IDLE.
- Direction changing mid-word does not abort; the word completes.
- Ticks cannot arrive outside IDLE (6-cycle transaction < CLK_DIV minimum of 8).
- Reset mid-transaction: FSM→IDLE, partial word discarded, no further fifo_read.

## Timing
- Reset values: fifo_read=0, sample_data=0, sample_valid=0, match=0, underrun_count=0, error_count=0, tick counter=0, FSM=IDLE.
- First tick in cycle CLK_DIV-1 after reset deasserts (counter=0 on first post-reset cycle).
- Tick at cycle T (accepted): fifo_read high T+1..T+4 (registered); bytes captured at the ends of T+2..T+5; sample_valid high in T+6 only; sample_data/match update in T+6 and hold until the next PRESENT.
- error_count updates visible in T+7; underrun_count visible in T+1 after the underrun tick.
- Exactly 4 fifo_read pulses per accepted tick, never more, never fewer.

## Structure
- Shared include: FSM state encodings, FIFO address width (11), byte-lane count (4), default EXPECTED, saturating max 16'hFFFF. The same include is used by dummy_adc benches.
- One sub-module: sample_tick_gen (parameter CLK_DIV; ports clk, reset, tick). Reusable by the ADC side.

## Test plan
- Reset, then FIFO preloaded EF,BE,AD,DE (level=4), direction=0 → at first tick 4 fifo_read pulses; sample_data=32'hDEADBEEF, sample_valid one cycle at T+6, match=1, error_count=0.
- Preload 01,02,03,04 → sample_data=32'h04030201, match=0, error_count=1.
- level=3 (addr_in=3, addr_out=0) at tick → no fifo_read, underrun_count=1; three such ticks → 3.
- Pointer wrap: addr_in=2, addr_out=2046 (level=4) → word read normally, no underrun.
- Assert reset in T+3 of a transaction → fifo_read low next cycle, all outputs 0, no sample_valid; next transaction after reset is correct.
- direction=1 for 10 ticks with level=64 → zero fifo_read, counters unchanged; force underrun_count=16'hFFFF then underrun tick → stays 16'hFFFF.
